// File: rtl/task_dispatcher.sv
// rtl/task_dispatcher.sv - push fan-out and two-phase root/subtree pop over a PIFO RPU array
// Optional statistics counters: TASK_DISPATCHER_STATS_EN
module task_dispatcher #(
    parameter int PTW          = 16,
    parameter int MTW          = 0,
    parameter int TREE_NUM     = 16,
    parameter int RPU_NUM      = 4,
    parameter int ROOT_RPU_ID  = 0,
    parameter int ROOT_TREE_ID = 0,
    parameter int CTW          = 10,
    parameter int POP_TIMEOUT  = 64,
    localparam int DW          = MTW + PTW,
    localparam int TNB         = $clog2(TREE_NUM),
    localparam int RNB         = $clog2(RPU_NUM)
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   i_push,
    input  logic [TNB-1:0]         i_push_tree_id,
    input  logic [DW-1:0]          i_push_data,
    output logic                   o_push_ready,
    output logic                   o_push_err,
    input  logic                   i_pop,
    output logic                   o_pop_ready,
    output logic                   o_pop_valid,
    output logic [TNB-1:0]         o_pop_tree_id,
    output logic [DW-1:0]          o_pop_data,
    output logic                   o_pop_error,
    output logic [RPU_NUM-1:0]     o_rpu_push,
    output logic [RPU_NUM*DW-1:0]  o_rpu_push_data,
    output logic [RPU_NUM*TNB-1:0] o_rpu_tree_id,
    output logic [RPU_NUM-1:0]     o_rpu_pop,
    input  logic [RPU_NUM-1:0]     i_rpu_pop_valid,
    input  logic [RPU_NUM*DW-1:0]  i_rpu_pop_data,
    input  logic [RPU_NUM-1:0]     i_rpu_full
`ifdef TASK_DISPATCHER_STATS_EN
   ,output logic [31:0]            o_stat_push,
    output logic [31:0]            o_stat_pop,
    output logic [31:0]            o_stat_timeout
`endif
);

    localparam int TMW = (POP_TIMEOUT > 2) ? $clog2(POP_TIMEOUT) : 1;
    localparam logic [TMW-1:0] TMO_LAST = TMW'(POP_TIMEOUT - 1);
    localparam logic [TNB-1:0] ROOT_TID = ROOT_TREE_ID[TNB-1:0];
    localparam logic [RNB-1:0] ROOT_RPU = ROOT_RPU_ID[RNB-1:0];
    localparam logic [TNB:0]   TREE_LIM = TREE_NUM[TNB:0];

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ROOT_POP  = 3'd1,
        ROOT_WAIT = 3'd2,
        SUB_POP   = 3'd3,
        SUB_WAIT  = 3'd4,
        RESP      = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CTW-1:0]         occ_q;
    logic [TMW-1:0]         timer_q;
    logic [TNB-1:0]         tid_q, tid_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   err_q, err_d;
    logic [RPU_NUM-1:0]     push_q;
    logic [RPU_NUM*DW-1:0]  push_data_q;
    logic [RPU_NUM*TNB-1:0] push_tid_q;
    logic                   push_err_q;
    logic [RPU_NUM-1:0]     rpu_pop;
    logic [RPU_NUM*TNB-1:0] rpu_tid;

    logic [RNB-1:0] push_rpu;
    logic [RNB-1:0] tid_rpu;
    logic           push_illegal;
    logic           push_fire;
    logic           push_ok;
    logic           pop_fire;
    logic           root_pop;
    logic           in_wait;
    logic           timeout;

    assign push_rpu     = i_push_tree_id[RNB-1:0];
    assign tid_rpu      = tid_q[RNB-1:0];
    assign push_illegal = (i_push_tree_id == ROOT_TID) || (push_rpu == ROOT_RPU)
                       || ({1'b0, i_push_tree_id} >= TREE_LIM);

    // Readiness is forced low while reset is held so nothing upstream sees a handshake.
    assign o_push_ready = i_arst_n && !i_rpu_full[ROOT_RPU_ID] && !i_rpu_full[push_rpu]
                       && (occ_q != '1) && !(state_q == SUB_POP && push_rpu == tid_rpu);
    assign o_pop_ready  = i_arst_n && (state_q == IDLE) && (occ_q != '0);

    assign push_fire = i_push && o_push_ready;
    assign push_ok   = push_fire && !push_illegal;
    assign pop_fire  = i_pop && o_pop_ready;
    assign root_pop  = (state_q == ROOT_POP);
    assign in_wait   = (state_q == ROOT_WAIT) || (state_q == SUB_WAIT);
    assign timeout   = in_wait && (timer_q == TMO_LAST);

    always_comb begin
        state_d       = state_q;
        tid_d         = tid_q;
        data_d        = data_q;
        err_d         = err_q;
        rpu_pop       = '0;
        o_pop_valid   = 1'b0;
        o_pop_tree_id = '0;
        o_pop_data    = '0;
        o_pop_error   = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (pop_fire) state_d = ROOT_POP;
            end
            ROOT_POP: begin
                rpu_pop[ROOT_RPU_ID] = 1'b1;
                state_d = ROOT_WAIT;
            end
            ROOT_WAIT: begin
                if (i_rpu_pop_valid[ROOT_RPU_ID]) begin
                    tid_d   = i_rpu_pop_data[ROOT_RPU_ID*DW +: TNB];
                    state_d = SUB_POP;
                end else if (timeout) begin
                    tid_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            SUB_POP: begin
                rpu_pop[tid_rpu] = 1'b1;
                state_d = SUB_WAIT;
            end
            SUB_WAIT: begin
                if (i_rpu_pop_valid[tid_rpu]) begin
                    data_d  = i_rpu_pop_data[int'(tid_rpu)*DW +: DW];
                    state_d = RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                o_pop_valid   = 1'b1;
                o_pop_tree_id = tid_q;
                o_pop_data    = err_q ? '1 : data_q;
                o_pop_error   = err_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The subtree pop lane carries the popped tree ID on top of the registered push IDs.
    always_comb begin
        rpu_tid = push_tid_q;
        if (state_q == SUB_POP) rpu_tid[int'(tid_rpu)*TNB +: TNB] = tid_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            timer_q     <= '0;
            tid_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            push_q      <= '0;
            push_data_q <= '0;
            push_tid_q  <= '0;
            push_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tid_q      <= tid_d;
            data_q     <= data_d;
            err_q      <= err_d;
            timer_q    <= (in_wait && state_d == state_q) ? timer_q + 1'b1 : '0;
            push_err_q <= push_fire && push_illegal;
            if (push_ok && !root_pop) occ_q <= occ_q + 1'b1;
            else if (!push_ok && root_pop) occ_q <= occ_q - 1'b1;
            push_q      <= '0;
            push_data_q <= '0;
            push_tid_q  <= '0;
            if (push_ok) begin
                push_q[ROOT_RPU_ID]                        <= 1'b1;
                push_data_q[ROOT_RPU_ID*DW +: DW]          <= DW'(i_push_tree_id);
                push_tid_q[ROOT_RPU_ID*TNB +: TNB]         <= ROOT_TID;
                push_q[push_rpu]                           <= 1'b1;
                push_data_q[int'(push_rpu)*DW +: DW]       <= i_push_data;
                push_tid_q[int'(push_rpu)*TNB +: TNB]      <= i_push_tree_id;
            end
        end
    end

    assign o_rpu_push      = push_q;
    assign o_rpu_push_data = push_data_q;
    assign o_rpu_tree_id   = rpu_tid;
    assign o_rpu_pop       = rpu_pop;
    assign o_push_err      = push_err_q;

`ifdef TASK_DISPATCHER_STATS_EN
    logic [31:0] stat_push_q, stat_pop_q, stat_tmo_q;

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            stat_push_q <= '0;
            stat_pop_q  <= '0;
            stat_tmo_q  <= '0;
        end else begin
            if (push_fire && stat_push_q != '1) stat_push_q <= stat_push_q + 1'b1;
            if (state_q == RESP && !err_q && stat_pop_q != '1) stat_pop_q <= stat_pop_q + 1'b1;
            if (state_q == RESP && err_q && stat_tmo_q != '1) stat_tmo_q <= stat_tmo_q + 1'b1;
        end
    end

    assign o_stat_push    = stat_push_q;
    assign o_stat_pop     = stat_pop_q;
    assign o_stat_timeout = stat_tmo_q;
`endif

endmodule

// File: tb/tb_task_dispatcher.sv
// tb/tb_task_dispatcher.sv - directed self-checking bench for task_dispatcher
module tb_task_dispatcher;

    logic        clk;
    logic        resetn;
    logic        i_push;
    logic [3:0]  i_push_tree_id;
    logic [15:0] i_push_data;
    logic        o_push_ready;
    logic        o_push_err;
    logic        i_pop;
    logic        o_pop_ready;
    logic        o_pop_valid;
    logic [3:0]  o_pop_tree_id;
    logic [15:0] o_pop_data;
    logic        o_pop_error;
    logic [3:0]  o_rpu_push;
    logic [63:0] o_rpu_push_data;
    logic [15:0] o_rpu_tree_id;
    logic [3:0]  o_rpu_pop;
    logic [3:0]  i_rpu_pop_valid;
    logic [63:0] i_rpu_pop_data;
    logic [3:0]  i_rpu_full;

    int n_cmp = 0;
    int n_bad = 0;

    task_dispatcher dut (
        .i_clk           (clk),
        .i_arst_n        (resetn),
        .i_push          (i_push),
        .i_push_tree_id  (i_push_tree_id),
        .i_push_data     (i_push_data),
        .o_push_ready    (o_push_ready),
        .o_push_err      (o_push_err),
        .i_pop           (i_pop),
        .o_pop_ready     (o_pop_ready),
        .o_pop_valid     (o_pop_valid),
        .o_pop_tree_id   (o_pop_tree_id),
        .o_pop_data      (o_pop_data),
        .o_pop_error     (o_pop_error),
        .o_rpu_push      (o_rpu_push),
        .o_rpu_push_data (o_rpu_push_data),
        .o_rpu_tree_id   (o_rpu_tree_id),
        .o_rpu_pop       (o_rpu_pop),
        .i_rpu_pop_valid (i_rpu_pop_valid),
        .i_rpu_pop_data  (i_rpu_pop_data),
        .i_rpu_full      (i_rpu_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] t, input logic [15:0] d);
        i_push = 1'b1;
        i_push_tree_id = t;
        i_push_data = d;
        #1;
        check("push_ready", o_push_ready, 1);
        tick;
        i_push = 1'b0;
    endtask

    // Drives the pop up to its SUB_POP cycle; root answers one cycle after its strobe.
    task automatic start_pop(input logic [15:0] root_word, input logic [3:0] tid, input logic [3:0] stray);
        logic [3:0]  exp_pop;
        logic [15:0] exp_tid;
        exp_pop = 4'b0001 << tid[1:0];
        exp_tid = 16'(tid) << (4 * tid[1:0]);
        i_pop = 1'b1;
        #1;
        check("pop_ready", o_pop_ready, 1);
        tick;
        i_pop = 1'b0;
        check("root_strobe", o_rpu_pop, 4'b0001);
        tick;
        check("root_wait_quiet", o_rpu_pop, 0);
        i_rpu_pop_valid = 4'b0001 | stray;
        i_rpu_pop_data = {16'hDEAD, 16'hDEAD, 16'hDEAD, root_word};
        tick;
        i_rpu_pop_valid = '0;
        i_rpu_pop_data = '0;
        check("sub_strobe", o_rpu_pop, exp_pop);
        check("sub_tree_id", o_rpu_tree_id, exp_tid);
    endtask

    task automatic finish_pop(input logic [3:0] tid, input logic [15:0] sub_word);
        tick;
        i_rpu_pop_valid = 4'b0001 << tid[1:0];
        i_rpu_pop_data = 64'(sub_word) << (16 * tid[1:0]);
        tick;
        i_rpu_pop_valid = '0;
        i_rpu_pop_data = '0;
        check("resp_valid", o_pop_valid, 1);
        check("resp_tree_id", o_pop_tree_id, tid);
        check("resp_data", o_pop_data, sub_word);
        check("resp_error", o_pop_error, 0);
        tick;
        check("resp_one_cycle", o_pop_valid, 0);
    endtask

    initial begin
        int early;
        int busy;
        resetn = 1'b0;
        i_push = 1'b0;
        i_push_tree_id = '0;
        i_push_data = '0;
        i_pop = 1'b0;
        i_rpu_pop_valid = '0;
        i_rpu_pop_data = '0;
        i_rpu_full = '0;
        tick;
        tick;
        check("rst_rpu_push", o_rpu_push, 0);
        check("rst_rpu_pop", o_rpu_pop, 0);
        check("rst_push_ready", o_push_ready, 0);
        check("rst_pop_ready", o_pop_ready, 0);
        check("rst_pop_valid", o_pop_valid, 0);
        check("rst_push_err", o_push_err, 0);
        resetn = 1'b1;
        tick;
        check("empty_pop_ready", o_pop_ready, 0);

        // Legal push t=5 fans out to root lane 0 and RPU 1
        push(4'd5, 16'hABCD);
        check("p5_strobe", o_rpu_push, 4'b0011);
        check("p5_data", o_rpu_push_data, 64'h0000_0000_ABCD_0005);
        check("p5_tree_id", o_rpu_tree_id, 16'h0050);
        check("p5_occ", o_pop_ready, 1);
        tick;
        check("p5_strobe_drop", o_rpu_push, 0);

        // t=4 maps onto the root RPU
        push(4'd4, 16'h5555);
        check("ill_err", o_push_err, 1);
        check("ill_strobe", o_rpu_push, 0);
        tick;
        check("ill_err_pulse", o_push_err, 0);
        push(4'd0, 16'h5555);
        check("ill_root_err", o_push_err, 1);
        check("ill_root_strobe", o_rpu_push, 0);
        tick;

        start_pop(16'h0005, 4'd5, 4'b0000);
        finish_pop(4'd5, 16'hABCD);
        check("p5_drained", o_pop_ready, 0);

        // t=6 with a stray valid from RPU 2 while the root is awaited
        push(4'd6, 16'h1111);
        check("p6_strobe", o_rpu_push, 4'b0101);
        check("p6_data", o_rpu_push_data, 64'h0000_1111_0000_0006);
        tick;
        start_pop(16'h0006, 4'd6, 4'b0100);
        finish_pop(4'd6, 16'h1111);
        check("p6_drained", o_pop_ready, 0);

        i_pop = 1'b1;
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (o_rpu_pop != 0 || o_pop_ready || o_pop_valid) busy++;
        end
        i_pop = 1'b0;
        check("empty_pop_ignored", busy, 0);

        // RPU 3 never answers the subtree pop
        push(4'd7, 16'h2222);
        check("p7_strobe", o_rpu_push, 4'b1001);
        tick;
        start_pop(16'h0007, 4'd7, 4'b0000);
        early = 0;
        for (int i = 0; i < 64; i++) begin
            tick;
            if (o_pop_valid) early++;
        end
        check("tmo_early", early, 0);
        tick;
        check("tmo_valid", o_pop_valid, 1);
        check("tmo_error", o_pop_error, 1);
        check("tmo_data", o_pop_data, 16'hFFFF);
        check("tmo_tree_id", o_pop_tree_id, 7);
        tick;
        check("tmo_one_cycle", o_pop_valid, 0);
        check("tmo_occ", o_pop_ready, 0);

        // Full flags block pushes
        i_rpu_full = 4'b0001;
        i_push = 1'b1;
        i_push_tree_id = 4'd9;
        i_push_data = 16'h3333;
        #1;
        check("full_root_ready", o_push_ready, 0);
        tick;
        check("full_no_strobe", o_rpu_push, 0);
        i_rpu_full = 4'b0010;
        #1;
        check("full_sub_ready", o_push_ready, 0);
        i_rpu_full = 4'b0000;
        #1;
        check("unfull_ready", o_push_ready, 1);
        tick;
        i_push = 1'b0;
        check("p9_strobe", o_rpu_push, 4'b0011);
        check("p9_data", o_rpu_push_data, 64'h0000_0000_3333_0009);
        tick;

        // Reset lands while waiting on the subtree
        start_pop(16'h0009, 4'd9, 4'b0000);
        tick;
        resetn = 1'b0;
        tick;
        check("mid_rst_rpu_pop", o_rpu_pop, 0);
        check("mid_rst_rpu_push", o_rpu_push, 0);
        check("mid_rst_tree_id", o_rpu_tree_id, 0);
        check("mid_rst_pop_valid", o_pop_valid, 0);
        resetn = 1'b1;
        i_rpu_pop_valid = 4'b0010;
        i_rpu_pop_data = 64'h0000_0000_3333_0000;
        tick;
        i_rpu_pop_valid = '0;
        i_rpu_pop_data = '0;
        busy = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_pop_valid || o_rpu_pop != 0) busy++;
            tick;
        end
        check("mid_rst_no_resp", busy, 0);
        check("mid_rst_occ", o_pop_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/task_dispatcher.md
Name: task_dispatcher

Overview:
- Parametrised successor to the single-level task generator; sits between the traffic front-end and an array of RPU_NUM PIFO RPUs.
- Maps each push to the root tree plus its subtree RPU, and tracks root occupancy.
- Runs a two-phase pop FSM: the root pop yields a tree ID, then the matching subtree is popped, with a handshake, timeout and error reporting.
- The PIFO array sits outside this block and is reached through flattened per-RPU ports.

Parameters:
- PTW, 16, payload width
- MTW, 0, metadata width; DW=MTW+PTW
- TREE_NUM, 16, number of trees; TNB=$clog2(TREE_NUM)
- RPU_NUM, 4, number of RPUs, power of two; RNB=$clog2(RPU_NUM)
- ROOT_RPU_ID, 0, RPU that holds the root tree
- ROOT_TREE_ID, 0, root tree ID; its low RNB bits must equal ROOT_RPU_ID
- CTW, 10, root occupancy counter width
- POP_TIMEOUT, 64, maximum wait cycles per pop phase

Ports:
- i_clk in 1: clock
- i_arst_n in 1: reset, synchronous, active-low
- i_push in 1: push request
- i_push_tree_id in TNB: target subtree
- i_push_data in DW: payload
- o_push_ready out 1: push accepted this cycle when i_push&o_push_ready
- o_push_err out 1: one-cycle pulse on an illegal push
- i_pop in 1: pop request
- o_pop_ready out 1: pop accepted when i_pop&o_pop_ready
- o_pop_valid out 1: one-cycle response pulse
- o_pop_tree_id out TNB: response tree ID
- o_pop_data out DW: response payload
- o_pop_error out 1: qualifies o_pop_valid on a timeout
- o_rpu_push out RPU_NUM: push strobe per RPU
- o_rpu_push_data out RPU_NUM*DW: push data per RPU
- o_rpu_tree_id out RPU_NUM*TNB: tree ID per RPU
- o_rpu_pop out RPU_NUM: pop strobe per RPU
- i_rpu_pop_valid in RPU_NUM: pop result valid per RPU
- i_rpu_pop_data in RPU_NUM*DW: pop result data per RPU
- i_rpu_full in RPU_NUM: full flag per RPU

Behaviour:
- **Reset.** All o_rpu_* = 0, o_push_ready/o_push_err/o_pop_* = 0, occupancy = 0, FSM = IDLE, timer = 0. Reset mid-pop aborts the pop with no response.
- **RPU mapping.** rpu(t) = t & (RPU_NUM-1).
- **Illegal push.** Tree ID equals ROOT_TREE_ID, or rpu(t) == ROOT_RPU_ID, or t >= TREE_NUM. The push is consumed with no effect, and o_push_err pulses at T+1.
- **Push ready.** o_push_ready = !i_rpu_full[ROOT_RPU_ID] & !i_rpu_full[rpu(t)] & occupancy != 2^CTW-1 & !(state==SUB_POP & rpu(t)==pop target).
- **Accepted push, cycle T. At T+1 (registered):**
  - o_rpu_push[ROOT_RPU_ID]=1 with data = zero-extended t and tree ID = ROOT_TREE_ID.
  - o_rpu_push[rpu(t)]=1 with i_push_data and tree ID t.
  - occupancy increments.
- **Idle lanes.** Unselected push data and tree IDs are driven to 0.
- **Pop ready.** o_pop_ready = (state==IDLE) & occupancy != 0. An i_pop while not ready is ignored.
- **FSM states:**
  - IDLE: accepted pop → ROOT_POP.
  - ROOT_POP: o_rpu_pop[ROOT_RPU_ID]=1 for one cycle; occupancy decrements → ROOT_WAIT.
  - ROOT_WAIT: on i_rpu_pop_valid[ROOT_RPU_ID], latch tid = data[TNB-1:0] → SUB_POP.
  - SUB_POP: o_rpu_pop[rpu(tid)]=1 and o_rpu_tree_id lane = tid, for one cycle → SUB_WAIT.
  - SUB_WAIT: on i_rpu_pop_valid[rpu(tid)], latch data → RESP.
  - RESP: o_pop_valid=1, o_pop_tree_id=tid, o_pop_data=latched data, for one cycle → IDLE.
- **Latency.** Pop accepted at T: o_rpu_pop[root] at T+1. Response no earlier than T+5 with a 1-cycle RPU latency.
- **Timer.** Cleared on entering each WAIT state. When it reaches POP_TIMEOUT in either WAIT state, go to RESP with o_pop_error=1, o_pop_data='1, o_pop_tree_id=tid (or 0 if the root phase timed out).
- **Simultaneous events.**
  - Root push and root pop in the same cycle are both issued.
  - Same-cycle occupancy increment and decrement leave the count unchanged.
  - A valid from a non-awaited RPU is ignored.

Optional Feature:
- Macro TASK_DISPATCHER_STATS_EN.
- **Defined:** adds ports o_stat_push (32), o_stat_pop (32) and o_stat_timeout (32).
  - Saturating counters of accepted pushes, completed pops and timeouts.
  - Reset to 0.
  - Counters update the cycle after the event.
- **Undefined:** these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Push t=5, data 0xABCD at T → at T+1, o_rpu_push=4'b0011; lane0 data 0x0005, tree ID 0; lane1 data 0xABCD, tree ID 5; occupancy=1.
- Push t=4 (maps to RPU 0) → o_push_err pulses at T+1, no o_rpu_push, occupancy unchanged.
- Push t=6 data 0x1111; pop; root returns 0x0006 one cycle after its strobe; RPU2 returns 0x1111 → o_pop_valid, tree ID 6, data 0x1111, error 0; occupancy=0.
- Pop with occupancy 0 → o_pop_ready=0, no o_rpu_pop activity for 10 cycles.
- Pop where RPU3 never answers the subtree pop → exactly 64 cycles after SUB_POP, o_pop_valid=1, o_pop_error=1, data 0xFFFF; FSM back in IDLE.
- i_rpu_full[0]=1 → o_push_ready=0; deassert → the next push is accepted. Reset asserted in SUB_WAIT → all outputs 0, no o_pop_valid afterwards.
